// File: rtl/cabac_byte_fetch_ctrl.sv
// Bitstream byte supply sequencer for the VVC arithmetic decoder: tracks the
// signed bits-needed counter, pulls bytes from the stream FIFO and stalls decode steps.
module cabac_byte_fetch_ctrl #(
    parameter int unsigned INIT_BYTES = 2,
    parameter int unsigned STALL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_valid,
    output logic               step_ready,
    input  logic               step_bypass,
    input  logic [2:0]         step_num_bits,
    input  logic [7:0]         bs_data,
    input  logic               bs_valid,
    output logic               bs_ready,
    output logic [3:0]         bits_needed,
    output logic               byte_load,
    output logic               byte_init,
    output logic [7:0]         byte_data,
    output logic [3:0]         byte_shift,
    output logic               busy,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int unsigned IDX_W       = (INIT_BYTES > 1) ? $clog2(INIT_BYTES) : 1;
    localparam logic [3:0]  BN_RESET    = 4'b1000;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t             state_q;
    logic [3:0]         bits_needed_q;
    logic               byte_load_q;
    logic               byte_init_q;
    logic [7:0]         byte_data_q;
    logic [3:0]         byte_shift_q;
    logic [3:0]         pend_shift_q;
    logic               busy_q;
    logic [STALL_W-1:0] stall_cnt_q;
    logic [IDX_W-1:0]   init_idx_q;

    logic [3:0] inc_c;
    logic [3:0] sum_c;
    logic       need_c;
    logic       accept_c;

    // Step arithmetic and handshake readiness for the current cycle.
    always_comb begin
        inc_c      = step_bypass ? 4'd1 : {1'b0, step_num_bits};
        sum_c      = bits_needed_q + inc_c;
        need_c     = ~sum_c[3];
        accept_c   = (state_q == RUN) && step_valid;
        step_ready = (state_q == RUN);
        bs_ready   = (state_q == INIT) || (state_q == WAIT) || (accept_c && need_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bits_needed_q <= BN_RESET;
            byte_load_q   <= 1'b0;
            byte_init_q   <= 1'b0;
            byte_data_q   <= 8'd0;
            byte_shift_q  <= 4'd0;
            pend_shift_q  <= 4'd0;
            busy_q        <= 1'b0;
            stall_cnt_q   <= '0;
            init_idx_q    <= '0;
        end else begin
            byte_load_q <= 1'b0;
            byte_init_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= INIT;
                        init_idx_q    <= '0;
                        stall_cnt_q   <= '0;
                        bits_needed_q <= BN_RESET;
                        busy_q        <= 1'b1;
                    end
                end
                INIT: begin
                    if (bs_valid) begin
                        byte_load_q  <= 1'b1;
                        byte_init_q  <= 1'b1;
                        byte_data_q  <= bs_data;
                        byte_shift_q <= 4'(init_idx_q);
                        if (init_idx_q == IDX_LAST) begin
                            state_q       <= RUN;
                            bits_needed_q <= BN_RESET;
                        end else begin
                            init_idx_q <= init_idx_q + IDX_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        if (need_c) begin
                            // Post-wrap value is committed now; the byte merge uses the pre-wrap sum.
                            bits_needed_q <= sum_c - 4'd8;
                            if (bs_valid) begin
                                byte_load_q  <= 1'b1;
                                byte_data_q  <= bs_data;
                                byte_shift_q <= sum_c;
                            end else begin
                                pend_shift_q <= sum_c;
                                state_q      <= WAIT;
                            end
                        end else begin
                            bits_needed_q <= sum_c;
                        end
                    end
                end
                WAIT: begin
                    if (stall_cnt_q != '1) begin
                        stall_cnt_q <= stall_cnt_q + STALL_W'(1);
                    end
                    if (bs_valid) begin
                        byte_load_q  <= 1'b1;
                        byte_data_q  <= bs_data;
                        byte_shift_q <= pend_shift_q;
                        state_q      <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bits_needed = bits_needed_q;
    assign byte_load   = byte_load_q;
    assign byte_init   = byte_init_q;
    assign byte_data   = byte_data_q;
    assign byte_shift  = byte_shift_q;
    assign busy        = busy_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_cabac_byte_fetch_ctrl.sv
// Bench for cabac_byte_fetch_ctrl: step vector table plus hand-written init, wait and reset
// sequences; every byte_load is checked against a queue of expected merges.
module tb_cabac_byte_fetch_ctrl;

    localparam int unsigned STALL_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               step_valid;
    logic               step_ready;
    logic               step_bypass;
    logic [2:0]         step_num_bits;
    logic [7:0]         bs_data;
    logic               bs_valid;
    logic               bs_ready;
    logic [3:0]         bits_needed;
    logic               byte_load;
    logic               byte_init;
    logic [7:0]         byte_data;
    logic [3:0]         byte_shift;
    logic               busy;
    logic [STALL_W-1:0] stall_cnt;

    cabac_byte_fetch_ctrl #(.INIT_BYTES(2), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .step_valid(step_valid), .step_ready(step_ready),
        .step_bypass(step_bypass), .step_num_bits(step_num_bits),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .bits_needed(bits_needed), .byte_load(byte_load), .byte_init(byte_init),
        .byte_data(byte_data), .byte_shift(byte_shift), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       byp;
        logic [2:0] nb;
        logic       bsv;
        logic [7:0] data;
        logic       exp_rdy;
        logic       exp_load;
        logic [3:0] exp_shift;
        logic [3:0] exp_bn;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [3:0] sh;
        logic       ini;
    } ld_t;

    vec_t vecs[$];
    ld_t  exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input logic [7:0] d, input logic [3:0] sh, input logic ini);
        ld_t e;
        e.d = d; e.sh = sh; e.ini = ini;
        exp_q.push_back(e);
    endtask

    // Every merge pulse must match the oldest outstanding expected byte.
    always @(negedge clk) begin
        if (byte_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_load", 32'(byte_data), 32'hFFFF_FFFF);
            end else begin
                ld_t e;
                e = exp_q.pop_front();
                chk("load_data", 32'(byte_data), 32'(e.d));
                chk("load_shift", 32'(byte_shift), 32'(e.sh));
                chk("load_init", 32'(byte_init), 32'(e.ini));
            end
        end
    end

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step_valid    = 1'b1;
            step_bypass   = vecs[i].byp;
            step_num_bits = vecs[i].nb;
            bs_valid      = vecs[i].bsv;
            bs_data       = vecs[i].data;
            #1;
            chk($sformatf("row%0d_step_ready", i), 32'(step_ready), 32'd1);
            chk($sformatf("row%0d_bs_ready", i), 32'(bs_ready), 32'(vecs[i].exp_rdy));
            if (vecs[i].exp_load) push_load(vecs[i].data, vecs[i].exp_shift, 1'b0);
            tick();
            chk($sformatf("row%0d_bits_needed", i), 32'(bits_needed), 32'(vecs[i].exp_bn));
        end
        step_valid = 1'b0;
        bs_valid   = 1'b0;
    endtask

    initial begin
        vecs.push_back('{1'b0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'hB});
        vecs.push_back('{1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'hD});
        vecs.push_back('{1'b0, 3'd1, 1'b1, 8'h99, 1'b0, 1'b0, 4'd0, 4'hE});
        vecs.push_back('{1'b0, 3'd5, 1'b1, 8'h7E, 1'b1, 1'b1, 4'd3, 4'hB});
        vecs.push_back('{1'b0, 3'd0, 1'b1, 8'h55, 1'b0, 1'b0, 4'd0, 4'hB});
        vecs.push_back('{1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'hF});
        for (int k = 1; k <= 7; k++)
            vecs.push_back('{1'b1, 3'd7, 1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 4'd0, 4'(8 + k)});
        vecs.push_back('{1'b1, 3'd7, 1'b1, 8'h48, 1'b1, 1'b1, 4'd0, 4'h8});
        vecs.push_back('{1'b0, 3'd7, 1'b1, 8'h60, 1'b0, 1'b0, 4'd0, 4'hF});
        vecs.push_back('{1'b0, 3'd7, 1'b1, 8'h61, 1'b1, 1'b1, 4'd6, 4'hE});
        vecs.push_back('{1'b0, 3'd7, 1'b1, 8'h62, 1'b1, 1'b1, 4'd5, 4'hD});
        vecs.push_back('{1'b0, 3'd7, 1'b1, 8'h63, 1'b1, 1'b1, 4'd4, 4'hC});

        rst = 1'b1; start = 1'b0; step_valid = 1'b0; step_bypass = 1'b0;
        step_num_bits = 3'd0; bs_data = 8'h00; bs_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_bits_needed", 32'(bits_needed), 32'h8);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step_ready", 32'(step_ready), 32'd0);
        chk("rst_bs_ready", 32'(bs_ready), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_byte_data", 32'(byte_data), 32'd0);
        chk("rst_byte_load", 32'(byte_load), 32'd0);

        // Slice init: two bytes loaded with index shifts.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_bs_ready", 32'(bs_ready), 32'd1);
        chk("init_step_ready", 32'(step_ready), 32'd0);
        bs_valid = 1'b1; bs_data = 8'hA5; push_load(8'hA5, 4'd0, 1'b1);
        tick();
        bs_data = 8'h3C; push_load(8'h3C, 4'd1, 1'b1);
        tick();
        bs_valid = 1'b0;
        #1;
        chk("run_step_ready", 32'(step_ready), 32'd1);
        chk("run_bits_needed", 32'(bits_needed), 32'h8);
        chk("run_bs_ready_idle", 32'(bs_ready), 32'd0);

        apply_rows(0, 5);

        // Bypass from -1 with no byte available: four stall cycles in WAIT.
        step_valid = 1'b1; step_bypass = 1'b1; bs_valid = 1'b0;
        #1;
        chk("wait_accept_bs_ready", 32'(bs_ready), 32'd1);
        tick();
        step_valid = 1'b0;
        chk("wait_bits_needed", 32'(bits_needed), 32'h8);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("wait%0d_step_ready", c), 32'(step_ready), 32'd0);
            chk($sformatf("wait%0d_bs_ready", c), 32'(bs_ready), 32'd1);
            tick();
        end
        chk("wait3_step_ready", 32'(step_ready), 32'd0);
        bs_valid = 1'b1; bs_data = 8'h11; push_load(8'h11, 4'd0, 1'b0);
        tick();
        bs_valid = 1'b0;
        #1;
        chk("wait_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("wait_back_run", 32'(step_ready), 32'd1);
        chk("wait_bits_after", 32'(bits_needed), 32'h8);

        // start outside IDLE must not restart or clear the stall count.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_stall", 32'(stall_cnt), 32'd4);
        chk("start_ignored_ready", 32'(step_ready), 32'd1);

        apply_rows(6, vecs.size() - 1);

        // Enter WAIT again, then reset with a byte arriving late.
        step_valid = 1'b1; step_bypass = 1'b0; step_num_bits = 3'd7; bs_valid = 1'b0;
        tick();
        step_valid = 1'b0;
        chk("wait2_step_ready", 32'(step_ready), 32'd0);
        chk("wait2_bits_needed", 32'(bits_needed), 32'hB);
        rst = 1'b1; bs_valid = 1'b1; bs_data = 8'hEE;
        tick();
        rst = 1'b0;
        #1;
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_bits_needed", 32'(bits_needed), 32'h8);
        chk("rstw_bs_ready", 32'(bs_ready), 32'd0);
        chk("rstw_step_ready", 32'(step_ready), 32'd0);
        chk("rstw_byte_data", 32'(byte_data), 32'd0);
        chk("rstw_byte_shift", 32'(byte_shift), 32'd0);
        chk("rstw_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        chk("rstw_no_load", 32'(byte_load), 32'd0);
        chk("rstw_still_idle", 32'(busy), 32'd0);
        bs_valid = 1'b0;
        tick(); tick();

        chk("pending_loads", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
